// File: rtl/button_press_decoder.sv
// Turns a debounced, clk-synchronous button level into single-cycle press, release,
// short, long and auto-repeat events, plus a held level.
module button_press_decoder #(
    parameter int COUNTER_BITS      = 27,
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int REPEAT_CYCLES     = 25_000_000,
    parameter bit REPEAT_EN         = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_stable,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam logic [COUNTER_BITS-1:0] LONG_LAST   = COUNTER_BITS'(LONG_PRESS_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] REPEAT_LAST = COUNTER_BITS'(REPEAT_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_ONE     = COUNTER_BITS'(1);

    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic                    press_q, press_d;
    logic                    release_q, release_d;
    logic                    short_q, short_d;
    logic                    long_q, long_d;
    logic                    repeat_q, repeat_d;
    logic                    held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (button_stable) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ONE;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                // Release takes priority over reaching the long threshold.
                if (!button_stable) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!button_stable) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = REPEAT_EN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Self-checking bench: two decoder instances (repeat enabled / disabled) compared each
// cycle against a run-length model of the button, plus directed event counts.
module tb_button_press_decoder;

    localparam int CB = 4;
    localparam int LP = 8;
    localparam int RP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic b0    = 1'b0;
    logic b1    = 1'b0;

    logic press0, release0, short0, long0, repeat0, held0;
    logic press1, release1, short1, long1, repeat1, held1;
    logic [5:0] obs0, obs1;
    logic [5:0] exp0, exp1;
    int run0, run1;
    int checks = 0;
    int errors = 0;

    assign obs0 = {press0, release0, short0, long0, repeat0, held0};
    assign obs1 = {press1, release1, short1, long1, repeat1, held1};

    button_press_decoder #(
        .COUNTER_BITS(CB), .LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP), .REPEAT_EN(1'b1)
    ) u_dut_rep (
        .clk(clk), .rst_n(rst_n), .button_stable(b0),
        .press_pulse(press0), .release_pulse(release0), .short_pulse(short0),
        .long_pulse(long0), .repeat_pulse(repeat0), .held(held0)
    );

    button_press_decoder #(
        .COUNTER_BITS(CB), .LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP), .REPEAT_EN(1'b0)
    ) u_dut_norep (
        .clk(clk), .rst_n(rst_n), .button_stable(b1),
        .press_pulse(press1), .release_pulse(release1), .short_pulse(short1),
        .long_pulse(long1), .repeat_pulse(repeat1), .held(held1)
    );

    always #5 clk = ~clk;

    // Reference: "run" is the number of consecutive 1 samples seen since the last 0.
    // Expected vector order: {press, release, short, long, repeat, held}.
    task automatic model_step(input logic b, input bit en, input int run_in,
                              output int run_out, output logic [5:0] e);
        logic p, r, s, l, rp;
        p = 1'b0; r = 1'b0; s = 1'b0; l = 1'b0; rp = 1'b0;
        if (b) begin
            run_out = run_in + 1;
            p  = (run_out == 1);
            l  = (run_out == LP);
            rp = en && (run_out > LP) && (((run_out - LP) % RP) == 0);
        end else begin
            r = (run_in > 0);
            s = (run_in > 0) && (run_in < LP);
            run_out = 0;
        end
        e = {p, r, s, l, rp, (run_out > 0)};
    endtask

    // Apply inputs, let one rising edge pass, then advance both models.
    task automatic step(input logic v0, input logic v1);
        int n0, n1;
        b0 = v0;
        b1 = v1;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            run0 = 0; run1 = 0; exp0 = '0; exp1 = '0;
        end else begin
            model_step(v0, 1'b1, run0, n0, exp0);
            model_step(v1, 1'b0, run1, n1, exp1);
            run0 = n0;
            run1 = n1;
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        run0 = 0; run1 = 0; exp0 = '0; exp1 = '0;
        checks++;
        if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
            errors++;
            $display("FAIL reset_immediate got %b/%b want 000000", obs0, obs1);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %b/%b want 000000", i, obs0, obs1);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
                errors++;
                $display("FAIL reset_release cyc%0d got %b/%b want 000000", i, obs0, obs1);
            end
        end
    endtask

    task automatic test_short_press();
        int held_cycles = 0;
        int shorts = 0;
        logic [2:0] pat [6] = '{3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0};
        for (int i = 0; i < 6; i++) begin
            step(i < 3, 1'b0);
            pat[i] = {press0, short0 & release0, long0};
            if (held0) held_cycles++;
            if (short0) shorts++;
            checks++;
            if (obs0 !== exp0) begin
                errors++;
                $display("FAIL short_press cyc%0d got %b want %b", i, obs0, exp0);
            end
        end
        checks++;
        if (held_cycles != 3 || shorts != 1 || pat[0] !== 3'b100 || pat[3] !== 3'b010) begin
            errors++;
            $display("FAIL short_press_shape held=%0d shorts=%0d e1=%b e4=%b want 3 1 100 010",
                     held_cycles, shorts, pat[0], pat[3]);
        end
    endtask

    task automatic test_long_repeat();
        int long_at = -1;
        int reps = 0;
        int shorts = 0;
        int rel_at = -1;
        int rep_sum = 0;
        for (int i = 1; i <= 23; i++) begin
            step(i <= 20, 1'b0);
            if (long0) long_at = i;
            if (repeat0) begin reps++; rep_sum += i; end
            if (short0) shorts++;
            if (release0) rel_at = i;
            checks++;
            if (obs0 !== exp0) begin
                errors++;
                $display("FAIL long_repeat edge%0d got %b want %b", i, obs0, exp0);
            end
        end
        checks++;
        if (long_at != 8 || reps != 3 || rep_sum != 48 || shorts != 0 || rel_at != 21) begin
            errors++;
            $display("FAIL long_repeat_shape long@%0d reps=%0d sum=%0d shorts=%0d rel@%0d want 8 3 48 0 21",
                     long_at, reps, rep_sum, shorts, rel_at);
        end
    endtask

    task automatic test_boundary();
        for (int len = 7; len <= 8; len++) begin
            int longs = 0;
            int shorts = 0;
            int rels = 0;
            for (int i = 1; i <= len + 2; i++) begin
                step(i <= len, 1'b0);
                longs += int'(long0);
                shorts += int'(short0);
                rels += int'(release0);
                checks++;
                if (obs0 !== exp0) begin
                    errors++;
                    $display("FAIL boundary_len%0d edge%0d got %b want %b", len, i, obs0, exp0);
                end
            end
            checks++;
            if (longs != (len == 8 ? 1 : 0) || shorts != (len == 7 ? 1 : 0) || rels != 1) begin
                errors++;
                $display("FAIL boundary_len%0d_counts long=%0d short=%0d rel=%0d", len, longs, shorts, rels);
            end
        end
    endtask

    task automatic test_repeat_disabled();
        int longs = 0;
        int reps = 0;
        int rels = 0;
        for (int i = 1; i <= 22; i++) begin
            step(1'b0, i <= 20);
            longs += int'(long1);
            reps += int'(repeat1);
            rels += int'(release1);
            checks++;
            if (obs1 !== exp1) begin
                errors++;
                $display("FAIL repeat_disabled edge%0d got %b want %b", i, obs1, exp1);
            end
        end
        checks++;
        if (longs != 1 || reps != 0 || rels != 1) begin
            errors++;
            $display("FAIL repeat_disabled_counts long=%0d rep=%0d rel=%0d want 1 0 1", longs, reps, rels);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs0 !== exp0 || obs1 !== exp1) begin
                errors++;
                $display("FAIL async_pre edge%0d got %b/%b want %b/%b", i, obs0, obs1, exp0, exp1);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        run0 = 0; run1 = 0; exp0 = '0; exp1 = '0;
        checks++;
        if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_immediate got %b/%b want 000000", obs0, obs1);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
                errors++;
                $display("FAIL async_reset_hold cyc%0d got %b/%b want 000000", i, obs0, obs1);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        checks++;
        if (obs0 !== exp0 || obs1 !== exp1 || press0 !== 1'b1 || release0 !== 1'b0) begin
            errors++;
            $display("FAIL async_repress got %b/%b want %b/%b", obs0, obs1, exp0, exp1);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs0 !== exp0 || obs1 !== exp1) begin
                errors++;
                $display("FAIL async_post cyc%0d got %b/%b want %b/%b", i, obs0, obs1, exp0, exp1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] ev [6];
        for (int i = 0; i < 6; i++) begin
            step(pat[i], 1'b0);
            ev[i] = {press0, release0, short0};
            checks++;
            if (obs0 !== exp0) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got %b want %b", i, obs0, exp0);
            end
        end
        checks++;
        if (ev[0] !== 3'b100 || ev[1] !== 3'b000 || ev[2] !== 3'b011 || ev[3] !== 3'b100 || ev[4] !== 3'b011) begin
            errors++;
            $display("FAIL back_to_back_order got %b %b %b %b %b want 100 000 011 100 011",
                     ev[0], ev[1], ev[2], ev[3], ev[4]);
        end
    endtask

    task automatic test_random();
        logic v0 = 1'b0;
        logic v1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) v0 = ~v0;
            if ($urandom_range(0, 9) == 0) v1 = ~v1;
            step(v0, v1);
            checks++;
            if (obs0 !== exp0 || obs1 !== exp1) begin
                errors++;
                $display("FAIL random cyc%0d got %b/%b want %b/%b", i, obs0, obs1, exp0, exp1);
            end
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        run0 = 0; run1 = 0; exp0 = '0; exp1 = '0;
        test_reset();
        test_short_press();
        test_long_repeat();
        test_boundary();
        test_repeat_disabled();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
